sd_feed_ctrl: RTL

SD_FEED_CTRL -- requirements
Module: sd_feed_ctrl

---
 rtl/sd_feed_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/sd_feed_ctrl.sv
// Serial stimulus feeder for a sequence detector: shifts a captured word out LSB first and
// counts the detector's registered hits. Optional repeat mode is enabled by `define SD_FEED_LOOP_EN.
module sd_feed_ctrl #(
  parameter int WIDTH = 16,
  parameter int CW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [CW-1:0]    len,
  input  logic             loop,
  output logic             bit_out,
  input  logic             det_in,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    match_count,
  output logic [CW-1:0]    first_idx,
  output logic             match_valid
);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;

  localparam logic [CW-1:0] LEN_MAX = CW'(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    len_q;
  logic [CW-1:0]    idx;
  logic [CW-1:0]    att_idx;
  logic             att_valid;
  logic             last_bit;
  logic             det_hit;

`ifdef SD_FEED_LOOP_EN
  logic [WIDTH-1:0] data_q;
`else
  logic unused_loop;
  assign unused_loop = loop;
`endif

  assign last_bit = (idx == len_q - CW'(1));
  // The detector answers one cycle late, so a hit is credited to the bit shown in the previous cycle.
  assign det_hit  = att_valid && det_in && ((state == SHIFT) || (state == DRAIN));

  // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      len_q       <= '0;
      idx         <= '0;
      att_idx     <= '0;
      att_valid   <= 1'b0;
      bit_out     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      match_count <= '0;
      first_idx   <= '0;
      match_valid <= 1'b0;
`ifdef SD_FEED_LOOP_EN
      data_q      <= '0;
`endif
    end else begin
      if (det_hit) begin
        if (match_count != '1) match_count <= match_count + CW'(1);
        if (!match_valid) begin
          first_idx   <= att_idx;
          match_valid <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (start && (len != '0) && (len <= LEN_MAX)) begin
            shreg       <= data_in;
            len_q       <= len;
            idx         <= '0;
            att_valid   <= 1'b0;
            bit_out     <= data_in[0];
            busy        <= 1'b1;
            match_count <= '0;
            first_idx   <= '0;
            match_valid <= 1'b0;
`ifdef SD_FEED_LOOP_EN
            data_q      <= data_in;
`endif
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          att_valid <= 1'b1;
          att_idx   <= idx;
          if (last_bit) begin
`ifdef SD_FEED_LOOP_EN
            if (loop) begin
              idx     <= '0;
              shreg   <= data_q;
              bit_out <= data_q[0];
            end else
`endif
            begin
              bit_out <= 1'b0;
              state   <= DRAIN;
            end
          end else begin
            idx     <= idx + CW'(1);
            shreg   <= shreg >> 1;
            bit_out <= shreg[1];
          end
        end
        DRAIN: begin
          att_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
